// File: rtl/airi5c_uart_pkg.sv
// Shared UART definitions for the TX and RX controllers.
// Holds the frame FSM state encoding, the data_bits and parity field codes,
// and small helpers that decode those fields.
package airi5c_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam logic [1:0] PARITY_NONE     = 2'b00;
  localparam logic [1:0] PARITY_EVEN     = 2'b01;
  localparam logic [1:0] PARITY_ODD      = 2'b10;
  localparam logic [1:0] PARITY_RESERVED = 2'b11;

  // Index of the last data bit of a frame: code 00 means five bits, so index 4.
  function automatic logic [2:0] last_bit_index(input logic [1:0] data_bits);
    return {1'b0, data_bits} + 3'd4;
  endfunction

  // The reserved parity code behaves exactly like "none".
  function automatic logic parity_enabled(input logic [1:0] parity);
    return (parity == PARITY_EVEN) || (parity == PARITY_ODD);
  endfunction

endpackage

// File: rtl/airi5c_uart_tx.sv
// TX slice constants: the transmitter top lives in airi5c_uart_tx_ctrl.sv.
// This file declares only a small package describing the TX frame size
// limits, shared by documentation and any future TX-side helpers.
package airi5c_uart_tx_doc_pkg;
  localparam int TX_FRAME_MAX_BITS = 12;
endpackage

// File: rtl/airi5c_uart_tx_baud.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk, reset, clear : clock, synchronous reset and synchronous abort
//   load              : frame start; captures baud_div and restarts the count
//   run               : a frame is in progress
//   baud_div          : bit period minus one, in clk cycles
//   tick              : one-cycle strobe in the last cycle of every bit period
module airi5c_uart_tx_baud
  import airi5c_uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt;

  // The divider is captured at frame start so a mid-frame change of
  // baud_div only affects the next frame.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= baud_div;
      cnt   <= '0;
    end else if (run) begin
      if (cnt == div_q) cnt <= '0;
      else              cnt <= cnt + DIV_WIDTH'(1);
    end
  end

  assign tick = run && (cnt == div_q);

endmodule

// File: rtl/airi5c_uart_tx_ctrl.sv
// UART transmit controller: pops words from the TX FIFO and serialises them
// as start bit, 5..8 data bits LSB first, optional parity and 1 or 2 stop bits.
// Ports:
//   clk, reset, clear  : clock, synchronous reset, synchronous frame abort
//   enable             : allows new frames to start
//   baud_div           : bit period minus one, in clk cycles
//   data_bits          : 00=5, 01=6, 10=7, 11=8 data bits
//   parity             : 00 none, 01 even, 10 odd, 11 none
//   stop_bits          : 0 one stop bit, 1 two stop bits
//   cts_en, cts        : flow control enable and clear-to-send
//   fifo_empty, fifo_data, fifo_pop : TX FIFO handshake
//   tx, busy, tx_done  : serial line, frame active, end-of-frame pulse
// DATA_WIDTH must be at least 8.
module airi5c_uart_tx_ctrl
  import airi5c_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [1:0]            data_bits,
  input  logic [1:0]            parity,
  input  logic                  stop_bits,
  input  logic                  cts_en,
  input  logic                  cts,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  uart_state_t           state, state_next;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [2:0]            bit_cnt;
  logic                  stop_cnt;
  logic                  par_acc;
  logic [1:0]            lat_dbits;
  logic [1:0]            lat_parity;
  logic                  lat_stop;
  logic                  start_cond;
  logic                  abort;
  logic                  tick;
  logic                  last_data;
  logic                  last_stop;

  assign abort      = reset || clear;
  assign start_cond = (state == IDLE) && enable && !fifo_empty && (!cts_en || cts);
  assign fifo_pop   = start_cond && !abort;
  assign last_data  = (bit_cnt == last_bit_index(lat_dbits));
  assign last_stop  = (stop_cnt == lat_stop);

  airi5c_uart_tx_baud #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .load     (start_cond),
    .run      (busy),
    .baud_div (baud_div),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (abort) state <= IDLE;
    else       state <= state_next;
  end

  // Every transition except the frame start waits for the bit-period tick.
  // tx_done is suppressed in an abort cycle so an aborted frame never
  // reports completion.
  always_comb begin
    state_next = state;
    tx         = 1'b1;
    tx_done    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_cond) state_next = START;
      end
      START: begin
        tx = 1'b0;
        if (tick) state_next = DATA;
      end
      DATA: begin
        tx = shift_q[0];
        if (tick && last_data) state_next = parity_enabled(lat_parity) ? PARITY : STOP;
      end
      PARITY: begin
        tx = (lat_parity == PARITY_ODD) ? ~par_acc : par_acc;
        if (tick) state_next = STOP;
      end
      STOP: begin
        tx_done = tick && last_stop && !abort;
        if (tick && last_stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: the word and its format are captured on the pop edge,
  // parity accumulates over the bits actually shifted out, so bits above the
  // configured width never reach tx or the parity.
  always_ff @(posedge clk) begin
    if (abort) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      par_acc    <= 1'b0;
      lat_dbits  <= DBITS_5;
      lat_parity <= PARITY_NONE;
      lat_stop   <= 1'b0;
    end else if (start_cond) begin
      shift_q    <= fifo_data;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      par_acc    <= 1'b0;
      lat_dbits  <= data_bits;
      lat_parity <= parity;
      lat_stop   <= stop_bits;
    end else if (tick) begin
      case (state)
        DATA: begin
          shift_q <= shift_q >> 1;
          par_acc <= par_acc ^ shift_q[0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        STOP: stop_cnt <= ~stop_cnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_airi5c_uart_tx_ctrl.sv
// Self-checking bench for airi5c_uart_tx_ctrl: a table of frame formats with
// hand-built expected bit sequences, plus directed sequences for reset,
// flow control, clear, and back-to-back frames.
module tb_airi5c_uart_tx_ctrl;

  typedef struct {
    logic [15:0] div;
    logic [1:0]  dbits;
    logic [1:0]  par;
    logic        stop;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] frame;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, clear, enable, stop_bits, cts_en, cts, fifo_empty;
  logic [15:0] baud_div;
  logic [1:0]  data_bits, parity;
  logic [7:0]  fifo_data;
  logic        fifo_pop, tx, busy, tx_done;

  int tests = 0;
  int failures = 0;
  int pop_count = 0;

  vec_t vecs[7];

  airi5c_uart_tx_ctrl #(
    .DATA_WIDTH(8),
    .DIV_WIDTH(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .enable     (enable),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity     (parity),
    .stop_bits  (stop_bits),
    .cts_en     (cts_en),
    .cts        (cts),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // Pops are counted independently of the checks to detect lost or extra pops.
  always @(negedge clk) if (fifo_pop === 1'b1) pop_count++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    baud_div   = v.div;
    data_bits  = v.dbits;
    parity     = v.par;
    stop_bits  = v.stop;
    fifo_data  = v.data;
    fifo_empty = 1'b0;
  endtask

  // Called at posedge+1; returns at the negedge of the pop cycle.
  task automatic wait_pop(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (fifo_pop === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    check_output("pop_timeout", 32'd0, 32'd1);
  endtask

  // Called at the negedge of the pop cycle; returns at the negedge of the
  // first idle cycle after the frame.
  // mode 0: FIFO emptied; 1: FIFO emptied and all config inputs scrambled;
  // 2: FIFO keeps a second word (0xC3) and parity switches to even.
  task automatic check_frame(input vec_t v, input int mode, input int drop_at);
    int  cyc;
    bit  last;
    cyc = 0;
    check_output("pop_cycle_tx", tx, 1);
    check_output("pop_cycle_busy", busy, 0);
    @(posedge clk); #1;
    case (mode)
      0: fifo_empty = 1'b1;
      1: begin
        fifo_empty = 1'b1;
        fifo_data  = ~v.data;
        data_bits  = ~v.dbits;
        parity     = ~v.par;
        stop_bits  = ~v.stop;
        baud_div   = v.div + 16'd5;
      end
      default: begin
        fifo_data = 8'hC3;
        parity    = 2'b01;
      end
    endcase
    for (int k = 0; k < v.nbits; k++) begin
      for (int c = 0; c <= int'(v.div); c++) begin
        cyc++;
        if (cyc == drop_at) begin
          cts    = 1'b0;
          enable = 1'b0;
        end
        @(negedge clk);
        last = (k == v.nbits - 1) && (c == int'(v.div));
        check_output($sformatf("tx_bit%0d", k), tx, v.frame[k]);
        check_output($sformatf("busy_bit%0d", k), busy, 1);
        check_output($sformatf("tx_done_bit%0d", k), tx_done, last);
        check_output($sformatf("no_pop_bit%0d", k), fifo_pop, 0);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check_output("end_busy", busy, 0);
    check_output("end_tx", tx, 1);
    check_output("end_tx_done", tx_done, 0);
  endtask

  initial begin
    bit   ok;
    int   p0;
    vec_t v;

    // div, data_bits, parity, stop, data, frame length, frame bits (bit0 first)
    vecs[0] = '{16'd3, 2'b11, 2'b00, 1'b0, 8'hA5, 10, 12'({1'b1, 8'hA5, 1'b0})};
    vecs[1] = '{16'd1, 2'b10, 2'b01, 1'b1, 8'h41, 11, 12'({2'b11, 1'b0, 7'h41, 1'b0})};
    vecs[2] = '{16'd2, 2'b00, 2'b10, 1'b0, 8'hFF, 8,  12'({1'b1, 1'b0, 5'h1F, 1'b0})};
    vecs[3] = '{16'd0, 2'b01, 2'b00, 1'b1, 8'h2C, 9,  12'({2'b11, 6'h2C, 1'b0})};
    vecs[4] = '{16'd0, 2'b11, 2'b10, 1'b0, 8'h00, 11, 12'({1'b1, 1'b1, 8'h00, 1'b0})};
    vecs[5] = '{16'd4, 2'b01, 2'b01, 1'b0, 8'hC7, 9,  12'({1'b1, 1'b1, 6'h07, 1'b0})};
    vecs[6] = '{16'd1, 2'b00, 2'b11, 1'b0, 8'h0A, 7,  12'({1'b1, 5'h0A, 1'b0})};

    reset = 1'b1; clear = 1'b0; enable = 1'b1; cts_en = 1'b0; cts = 1'b0;
    fifo_empty = 1'b0; fifo_data = 8'h55; baud_div = 16'd0;
    data_bits = 2'b11; parity = 2'b00; stop_bits = 1'b0;

    // Reset holds everything idle even with a word waiting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("reset_tx", tx, 1);
      check_output("reset_busy", busy, 0);
      check_output("reset_tx_done", tx_done, 0);
      check_output("reset_pop", fifo_pop, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    fifo_empty = 1'b1;
    @(posedge clk); #1;

    // Table of frame formats; config inputs are scrambled mid-frame.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i]);
      p0 = pop_count;
      wait_pop(1, ok);
      if (ok) check_frame(vecs[i], 1, -1);
      @(posedge clk); #1;
      check_output($sformatf("pop_once_v%0d", i), pop_count - p0, 1);
    end

    // enable low and cts low both block the start.
    v = '{16'd1, 2'b11, 2'b00, 1'b0, 8'h5A, 10, 12'({1'b1, 8'h5A, 1'b0})};
    apply_stimulus(v);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("enable_low_pop", fifo_pop, 0);
      @(posedge clk); #1;
    end
    enable = 1'b1; cts_en = 1'b1; cts = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("cts_low_pop", fifo_pop, 0);
      check_output("cts_low_tx", tx, 1);
      check_output("cts_low_busy", busy, 0);
      @(posedge clk); #1;
    end
    cts = 1'b1;
    p0 = pop_count;
    wait_pop(1, ok);
    if (ok) check_frame(v, 0, 8);
    @(posedge clk); #1;
    check_output("cts_pop_once", pop_count - p0, 1);
    cts_en = 1'b0; enable = 1'b1;

    // clear wins over a valid start condition in IDLE.
    fifo_empty = 1'b0; clear = 1'b1;
    @(negedge clk);
    check_output("clear_idle_pop", fifo_pop, 0);
    check_output("clear_idle_tx", tx, 1);
    @(posedge clk); #1;
    clear = 1'b0; fifo_empty = 1'b1;
    @(posedge clk); #1;

    // clear during data bit 3 (8N1, div 1: cycles 9-10 after the pop).
    v = '{16'd1, 2'b11, 2'b00, 1'b0, 8'h96, 10, 12'({1'b1, 8'h96, 1'b0})};
    apply_stimulus(v);
    p0 = pop_count;
    wait_pop(1, ok);
    @(posedge clk); #1;
    fifo_empty = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    clear = 1'b1; fifo_empty = 1'b0;
    @(negedge clk);
    check_output("clear_mid_busy", busy, 1);
    check_output("clear_mid_tx_done", tx_done, 0);
    check_output("clear_mid_pop", fifo_pop, 0);
    @(posedge clk); #1;
    clear = 1'b0; fifo_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("after_clear_tx", tx, 1);
      check_output("after_clear_busy", busy, 0);
      check_output("after_clear_tx_done", tx_done, 0);
      @(posedge clk); #1;
    end
    check_output("clear_pop_count", pop_count - p0, 1);

    // reset mid-frame abandons the word.
    apply_stimulus(v);
    p0 = pop_count;
    wait_pop(1, ok);
    @(posedge clk); #1;
    fifo_empty = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("after_reset_tx", tx, 1);
      check_output("after_reset_busy", busy, 0);
      @(posedge clk); #1;
    end
    check_output("reset_pop_count", pop_count - p0, 1);

    // Back-to-back at div 0: frame 1 without parity, one idle cycle with the
    // second pop, frame 2 with the parity selected during frame 1.
    v = '{16'd0, 2'b11, 2'b00, 1'b0, 8'h3C, 10, 12'({1'b1, 8'h3C, 1'b0})};
    apply_stimulus(v);
    p0 = pop_count;
    wait_pop(1, ok);
    if (ok) begin
      check_frame(v, 2, -1);
      check_output("b2b_idle_pop", fifo_pop, 1);
      v = '{16'd0, 2'b11, 2'b01, 1'b0, 8'hC3, 11, 12'({1'b1, 1'b0, 8'hC3, 1'b0})};
      if (fifo_pop === 1'b1) check_frame(v, 0, -1);
    end
    @(posedge clk); #1;
    check_output("b2b_pop_count", pop_count - p0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/airi5c_uart_tx_ctrl.md
AIRI5C_UART_TX_CTRL -- requirements
Module: airi5c_uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, max frame data width and width of fifo_data.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of baud_div.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous abort of any frame, same effect as reset.
REQ-006 SHALL have port enable  input  1  permits starting new frames.
REQ-007 SHALL have port baud_div  input  DIV_WIDTH  bit period minus one, in clk cycles.
REQ-008 SHALL have port data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits.
REQ-009 SHALL have port parity  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-010 SHALL have port stop_bits  input  1  0=one stop bit, 1=two stop bits.
REQ-011 SHALL have port cts_en / cts  input  1 / 1  flow control enable / clear-to-send (active high).
REQ-012 SHALL have port fifo_empty / fifo_data  input  1 / DATA_WIDTH  TX FIFO status and head word.
REQ-013 SHALL have port fifo_pop  output  1  one-cycle pop strobe to TX FIFO.
REQ-014 SHALL have port tx / busy / tx_done  output  1 each  serial line, frame active, end-of-frame pulse.

Function
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 Start condition: state IDLE, enable=1, fifo_empty=0, (cts_en=0 or cts=1).
REQ-017 fifo_pop SHALL be asserted combinationally for exactly the one cycle the start condition holds; no pop is issued in any other state.
REQ-018 On that edge: load fifo_data into shift register; latch data_bits, parity, stop_bits, baud_div; state -> START.
REQ-019 Latched config SHALL govern the whole frame; input changes mid-frame take effect only at the next frame.
REQ-020 Each bit SHALL last exactly baud_div+1 clk cycles; baud_div=0 gives one cycle per bit.
REQ-021 tx: START drives 0; DATA drives data LSB first, exactly the latched count of bits; PARITY drives the parity bit; STOP and IDLE drive 1.
REQ-022 PARITY state SHALL be skipped when parity is none; even = XOR of transmitted data bits, odd = its inverse; bits above data_bits are ignored.
REQ-023 STOP SHALL last 1 or 2 bit periods per latched stop_bits, then return to IDLE.
REQ-024 busy SHALL be 1 in every non-IDLE state, 0 in IDLE.
REQ-025 tx_done SHALL pulse high during the last cycle of the final stop bit only.
REQ-026 Back-to-back: at least one IDLE cycle (tx=1) SHALL separate consecutive frames; pop occurs in that IDLE cycle if the start condition holds.
REQ-027 Deassertion of enable or cts mid-frame SHALL NOT affect the current frame.
REQ-028 clear SHALL have priority over all other inputs; no pop, no tx_done in that cycle; tx=1 from the next cycle.

Reset
REQ-029 On reset or clear: state IDLE, tx=1, busy=0, tx_done=0, fifo_pop=0, baud and bit counters and shift register 0.
REQ-030 Reset mid-frame SHALL abandon the frame; the popped word is lost, not re-popped.

Structure
REQ-031 FSM state encodings and the data_bits and parity code constants SHALL live in the shared UART package/include, shared with the RX controller.
REQ-032 Bit-period timing SHALL be one sub-module, airi5c_uart_tx_baud: counter reloaded at frame start, one-cycle tick at bit end.

Verification
REQ-033 baud_div=3, 8N1, FIFO=0xA5 -> one pop; tx: 0 x4, then 1,0,1,0,0,1,0,1 x4 each, then 1 x4; tx_done in cycle 40 after pop.
REQ-034 7E2, data 0x41 -> 11-bit frame, data 1000001 LSB first, parity 0, two stop bits; busy high for 11*(baud_div+1) cycles.
REQ-035 5O1, data 0xFF -> data bits 11111 only, parity 0; upper bits never appear on tx.
REQ-036 cts_en=1, cts=0, FIFO non-empty -> no pop, tx=1; cts rises -> pop same cycle; cts falls mid-DATA -> frame completes unchanged.
REQ-037 clear asserted in DATA bit 3 -> tx=1, busy=0 next cycle, no tx_done, FIFO pop count unchanged.
REQ-038 baud_div=0, two words queued, parity switched to even during frame 1 -> frame 1 without parity, exactly one idle cycle, frame 2 with even parity.
